// File: rtl/sqrt2_unit_arbiter.sv
// Round-robin arbiter that shares one (a+b)/sqrt2, (a-b)/sqrt2 butterfly unit
// between the W8^1 (port 0) and W8^3 (port 1) twiddle paths of an 8-point FFT.
module sqrt2_unit_arbiter #(
  parameter int N   = 3,
  parameter int LAT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [(2**N)-1:0]   req0_a,
  input  logic [(2**N)-1:0]   req0_b,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [(2**N)-1:0]   req1_a,
  input  logic [(2**N)-1:0]   req1_b,
  output logic [(2**N)-1:0]   dp_in_1,
  output logic [(2**N)-1:0]   dp_in_2,
  input  logic [(2**N)-1:0]   dp_add,
  input  logic [(2**N)-1:0]   dp_sub,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [(2**N)-1:0]   rsp_add,
  output logic [(2**N)-1:0]   rsp_sub,
  output logic [3:0]          inflight
);

  logic            last_grant;
  logic            gnt_vld;
  logic            gnt_id;
  logic [LAT-1:0]  tag_vld_p;
  logic [LAT-1:0]  tag_id_p;
  logic            out_vld;
  logic            out_id;
  logic [3:0]      inflight_q;

  // Issue stage: grant, handshake and operand steering all happen this cycle
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = ~last_grant;
      end else if (req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld && gnt_id;

  always_comb begin
    dp_in_1 = '0;
    dp_in_2 = '0;
    if (gnt_vld) begin
      dp_in_1 = gnt_id ? req1_a : req0_a;
      dp_in_2 = gnt_id ? req1_b : req0_b;
    end
  end

  // A grant is always a handshake, since ready is only raised toward a valid port
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt_vld) begin
      last_grant <= gnt_id;
    end
  end

  // Tag pipeline: stage i holds the issue from i+1 cycles ago, matching the unit latency
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_p <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        tag_vld_p[i] <= tag_vld_p[i-1];
      end
      tag_vld_p[0] <= gnt_vld;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      tag_id_p[i] <= tag_id_p[i-1];
    end
    tag_id_p[0] <= gnt_id;
  end

  // Response stage: the oldest tag names the owner of the current unit output
  assign out_vld    = tag_vld_p[LAT-1];
  assign out_id     = tag_id_p[LAT-1];
  assign rsp0_valid = out_vld && !out_id;
  assign rsp1_valid = out_vld && out_id;
  assign rsp_add    = out_vld ? dp_add : '0;
  assign rsp_sub    = out_vld ? dp_sub : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 4'd0;
    end else begin
      case ({gnt_vld, out_vld})
        2'b10:   inflight_q <= inflight_q + 4'd1;
        2'b01:   inflight_q <= inflight_q - 4'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight = inflight_q;

endmodule

// File: tb/tb_sqrt2_unit_arbiter.sv
// Scoreboard bench for sqrt2_unit_arbiter; the shared unit is modelled as a
// pure LAT-cycle delay so routing of every operand pair is exactly checkable.
module tb_sqrt2_unit_arbiter;

  localparam int N   = 3;
  localparam int LAT = 3;
  localparam int W   = 2**N;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0] dp_in_1, dp_in_2, dp_add, dp_sub;
  logic         rsp0_valid, rsp1_valid;
  logic [W-1:0] rsp_add, rsp_sub;
  logic [3:0]   inflight;

  sqrt2_unit_arbiter #(.N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .dp_in_1(dp_in_1), .dp_in_2(dp_in_2), .dp_add(dp_add), .dp_sub(dp_sub),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_add(rsp_add), .rsp_sub(rsp_sub), .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit model: operands reappear LAT cycles later
  logic [W-1:0] d1 [LAT];
  logic [W-1:0] d2 [LAT];
  always @(posedge clk) begin
    d1[0] <= dp_in_1;
    d2[0] <= dp_in_2;
    for (int i = 1; i < LAT; i++) begin
      d1[i] <= d1[i-1];
      d2[i] <= d2[i-1];
    end
  end
  assign dp_add = d1[LAT-1];
  assign dp_sub = d2[LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           due;
  } exp_t;

  exp_t q[$];
  logic mlast = 1'b1;

  // Reference model and scoreboard, evaluated mid-cycle on every cycle
  logic         m_gv, m_gid, m_due;
  logic [W-1:0] m_in1, m_in2;
  exp_t         m_head;
  always @(negedge clk) begin
    m_gv  = 1'b0;
    m_gid = 1'b0;
    if (!rst && (req0_valid || req1_valid)) begin
      m_gv  = 1'b1;
      m_gid = (req0_valid && req1_valid) ? !mlast : !req0_valid;
    end
    m_in1 = !m_gv ? '0 : (m_gid ? req1_a : req0_a);
    m_in2 = !m_gv ? '0 : (m_gid ? req1_b : req0_b);
    chk_eq("ready0", req0_ready, m_gv && !m_gid);
    chk_eq("ready1", req1_ready, m_gv && m_gid);
    chk_eq("dp_in_1", dp_in_1, m_in1);
    chk_eq("dp_in_2", dp_in_2, m_in2);
    chk_eq("inflight", inflight, q.size());

    m_due = (q.size() > 0) && (q[0].due == cyc);
    if (m_due) begin
      m_head = q.pop_front();
      chk_eq("rsp0_valid", rsp0_valid, !m_head.id);
      chk_eq("rsp1_valid", rsp1_valid, m_head.id);
      chk_eq("rsp_add", rsp_add, m_head.a);
      chk_eq("rsp_sub", rsp_sub, m_head.b);
    end else begin
      chk_eq("rsp0_idle", rsp0_valid, 1'b0);
      chk_eq("rsp1_idle", rsp1_valid, 1'b0);
      chk_eq("rsp_add_idle", rsp_add, '0);
      chk_eq("rsp_sub_idle", rsp_sub, '0);
    end

    if (m_gv) begin
      q.push_back('{id: m_gid, a: m_in1, b: m_in2, due: cyc + LAT});
      mlast = m_gid;
    end
    if (rst) begin
      q.delete();
      mlast = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic v1, input logic [W-1:0] a1, input logic [W-1:0] b1);
    req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 8'h11, 8'h22, 1'b1, 8'h33, 8'h44);

    // Reset held two cycles with both requesters valid
    repeat (2) begin
      step();
      #2;
      chk_eq("rst_ready0", req0_ready, 1'b0);
      chk_eq("rst_ready1", req1_ready, 1'b0);
      chk_eq("rst_dp_in_1", dp_in_1, 8'h00);
      chk_eq("rst_rsp0", rsp0_valid, 1'b0);
      chk_eq("rst_inflight", inflight, 4'd0);
    end
    step();
    rst = 1'b0;
    #2;
    chk_eq("first_tie_ready0", req0_ready, 1'b1);
    chk_eq("first_tie_ready1", req1_ready, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    repeat (LAT + 1) step();

    // Single issue from requester 0
    drive(1'b1, 8'h40, 8'h24, 1'b0, 8'h00, 8'h00);
    #2;
    chk_eq("single_dp_in_1", dp_in_1, 8'h40);
    chk_eq("single_dp_in_2", dp_in_2, 8'h24);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    step();
    step();
    #2;
    chk_eq("single_rsp0", rsp0_valid, 1'b1);
    chk_eq("single_rsp1", rsp1_valid, 1'b0);
    chk_eq("single_add", rsp_add, 8'h40);
    chk_eq("single_sub", rsp_sub, 8'h24);
    repeat (LAT) step();

    // Lone requester 1 for four cycles: back-to-back issues and responses
    for (int k = 0; k < 7; k++) begin
      if (k < 4) drive(1'b0, 8'h00, 8'h00, 1'b1, 8'(8'h50 + k), 8'(8'hA0 + k));
      else       drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      #2;
      if (k < 4) chk_eq("lone_ready1", req1_ready, 1'b1);
      if (k >= 3) begin
        chk_eq("lone_rsp1", rsp1_valid, 1'b1);
        chk_eq("lone_add", rsp_add, 8'(8'h50 + k - 3));
      end
      step();
    end
    repeat (LAT) step();

    // Contention: six cycles with both valid, grants must alternate starting at 0
    for (int k = 0; k < 9; k++) begin
      if (k < 6) drive(1'b1, 8'(8'h10 + k), 8'(8'h20 + k), 1'b1, 8'(8'h80 + k), 8'(8'h90 + k));
      else       drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
      #2;
      if (k < 6) begin
        chk_eq("tie_ready0", req0_ready, (k % 2) == 0);
        chk_eq("tie_ready1", req1_ready, (k % 2) == 1);
      end
      if (k >= 3 && k < 6) chk_eq("tie_inflight", inflight, 4'd3);
      if (k >= 3) begin
        chk_eq("tie_rsp0", rsp0_valid, ((k - 3) % 2) == 0);
        chk_eq("tie_rsp1", rsp1_valid, ((k - 3) % 2) == 1);
        chk_eq("tie_add", rsp_add, ((k - 3) % 2) == 0 ? 8'(8'h10 + k - 3) : 8'(8'h80 + k - 3));
      end
      step();
    end
    repeat (2) step();

    // Reset while two operations are in flight
    drive(1'b1, 8'h61, 8'h71, 1'b0, 8'h00, 8'h00);
    step();
    drive(1'b1, 8'h62, 8'h72, 1'b0, 8'h00, 8'h00);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk_eq("midrst_rsp0_t3", rsp0_valid, 1'b0);
    chk_eq("midrst_rsp1_t3", rsp1_valid, 1'b0);
    chk_eq("midrst_inflight", inflight, 4'd0);
    step();
    #2;
    chk_eq("midrst_rsp0_t4", rsp0_valid, 1'b0);
    chk_eq("midrst_rsp1_t4", rsp1_valid, 1'b0);
    step();

    // Withdrawal: requester 1 loses a tie and drops valid; next tie is its turn
    drive(1'b1, 8'h71, 8'h01, 1'b1, 8'h72, 8'h02);
    #2;
    chk_eq("wd_ready0", req0_ready, 1'b1);
    chk_eq("wd_ready1", req1_ready, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    repeat (LAT + 1) step();
    drive(1'b1, 8'h73, 8'h03, 1'b1, 8'h74, 8'h04);
    #2;
    chk_eq("wd_next_ready1", req1_ready, 1'b1);
    chk_eq("wd_next_ready0", req0_ready, 1'b0);
    step();

    // Random traffic, checked entirely by the scoreboard
    repeat (60) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
      step();
    end
    drive(1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
    repeat (LAT + 2) step();
    #2;
    chk_eq("drain_queue", q.size(), 0);
    chk_eq("drain_inflight", inflight, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sqrt2_unit_arbiter.md
Name: sqrt2_unit_arbiter

Overview:
- Shares one (a+b)/sqrt2, (a-b)/sqrt2 butterfly unit between two requesters of the 8-point FFT twiddle stage (W8^1 path = requester 0, W8^3 path = requester 1).
- Round-robin arbitration with a valid/ready handshake on each request port.
- Drives the shared unit's operand inputs.
- Tracks in-flight operations in a tag pipeline matched to the unit's fixed latency, and returns each result to the requester that issued it.

Parameters:
- N, 3, data width is 2**N bits (8 at default); must match the shared unit.
- LAT, 3, shared unit latency in clk cycles from operand input to result output; legal range 1..8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operand pair
- req0_ready  out  1  requester 0 pair accepted this cycle
- req0_a, req0_b  in  2**N  requester 0 operands
- req1_valid  in  1  requester 1 has an operand pair
- req1_ready  out  1  requester 1 pair accepted this cycle
- req1_a, req1_b  in  2**N  requester 1 operands
- dp_in_1, dp_in_2  out  2**N  operands to shared unit (in_1, in_2)
- dp_add, dp_sub  in  2**N  shared unit results (add_sqrt_2, sub_sqrt_2)
- rsp0_valid  out  1  result for requester 0 present
- rsp1_valid  out  1  result for requester 1 present
- rsp_add, rsp_sub  out  2**N  result data, shared by both response ports
- inflight  out  4  operations issued but not yet returned

Behaviour:
- Single clock domain on clk. rst is synchronous active-high.
- Reset state:
  - tag pipeline cleared (all stage valids 0);
  - last_grant = 1, so requester 0 wins the first contention;
  - inflight = 0.
- During rst: req0_ready = req1_ready = 0 regardless of valids; dp_in_1 = dp_in_2 = 0.
- Grant (combinational, registered state last_grant):
  - only req0_valid → grant 0;
  - only req1_valid → grant 1;
  - both valid → grant = ~last_grant;
  - neither valid → no grant.
  - reqX_ready = grant to X. At most one ready high per cycle.
- A handshake (valid & ready) on port X:
  - last_grant <= X; last_grant holds when there is no grant.
  - Stage 0 of the tag pipeline loads {valid=1, id=X}.
  - dp_in_1/dp_in_2 = granted requester's a/b in that same cycle; 0 when there is no grant.
  - Requesters hold valid and operands stable until ready. Dropping valid before ready is legal: the request is withdrawn and nothing is issued.
- Tag pipeline:
  - LAT stages of {valid, id}; advances every cycle unconditionally.
  - The shared unit cannot stall, so responses have no backpressure.
- Response:
  - When stage LAT-1 has valid=1, rsp{id}_valid = 1 for exactly one cycle.
  - That cycle is LAT cycles after the handshake.
  - rsp_add = dp_add and rsp_sub = dp_sub, combinational pass-through.
  - rsp0_valid and rsp1_valid are never high together. With no valid response, rsp_add = rsp_sub = 0.
- Throughput: one issue per cycle sustained. Two continuously valid requesters alternate 0,1,0,1…
- Results return in issue order; no reordering.
- inflight:
  - +1 per issue, -1 per response, unchanged when both occur in the same cycle;
  - max value LAT, never wraps;
  - equals the number of valid tag stages.
- Reset mid-operation:
  - all in-flight tags are discarded; no rsp_valid for them;
  - for LAT cycles after rst deasserts, rsp_valid stays low unless a new issue occurs, even though dp_add/dp_sub may still carry stale data.
- Arithmetic: no computation inside this block; widths pass through unchanged at 2**N bits.

Test Plan:
Bench models the shared unit as a pure LAT-cycle delay (dp_add = in_1, dp_sub = in_2 delayed), so routing is exactly checkable; N=3, LAT=3.
- Reset: hold rst 2 cycles with both valids high → both readys 0, dp_in 0, rsp valids 0, inflight 0. First cycle after reset, both valid → req0_ready=1.
- Single issue: req0 a=0x40, b=0x24 at cycle t → dp_in_1=0x40, dp_in_2=0x24 at t; rsp0_valid=1 at t+3 with rsp_add=0x40, rsp_sub=0x24; rsp1_valid stays 0.
- Contention: both valid for 6 cycles, req0 a=0x10+k, req1 a=0x80+k → grants 0,1,0,1,0,1; responses alternate rsp0/rsp1 from t+3 with matching a values; inflight reaches 3 and holds.
- Lone requester: req1 valid 4 consecutive cycles, req0 idle → req1_ready=1 every cycle; four rsp1_valid pulses back-to-back.
- Mid-flight reset: issue at t and t+1, assert rst at t+2 for 1 cycle → no rsp valid at t+3 or t+4; inflight=0 at t+3.
- Withdrawal: req1_valid pulses 1 cycle while req0 wins the tie, then drops → no issue for requester 1, no rsp1_valid; last_grant=0, so the next tie goes to requester 1.
